// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the EV22 fetch stage: datapath widths, the NOP word
// and the control-flow opcode nybbles that the redirect source also decodes.
package ifetch_stage_pkg;

  localparam int unsigned IFETCH_AW = 12;
  localparam int unsigned IFETCH_IW = 20;

  localparam logic [IFETCH_IW-1:0] NOP_WORD = '0;

  // Opcode lives in the top nybble of the instruction word.
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_JMP = 4'h8,
    OP_JZE = 4'h9,
    OP_JNE = 4'hA,
    OP_JCY = 4'hB,
    OP_BSR = 4'hC,
    OP_RET = 4'hD
  } opcode_e;

  function automatic logic [3:0] inst_opcode(input logic [IFETCH_IW-1:0] inst);
    return inst[IFETCH_IW-1 -: 4];
  endfunction

  function automatic logic is_flow_op(input logic [3:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_JMP, OP_JZE, OP_JNE, OP_JCY, OP_BSR, OP_RET: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ifetch_stage_fetch_skid.sv
// One-entry instruction+PC holding buffer that catches the in-flight ROM word
// when the decoder stalls; clear has priority over load, load over drain.
module fetch_skid
  import ifetch_stage_pkg::*;
#(
  parameter int unsigned AW = IFETCH_AW,
  parameter int unsigned IW = IFETCH_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic          clear,
  input  logic [IW-1:0] in_inst,
  input  logic [AW-1:0] in_pc,
  output logic [IW-1:0] skid_inst,
  output logic [AW-1:0] skid_pc,
  output logic          skid_v
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_v    <= 1'b0;
      skid_inst <= '0;
      skid_pc   <= '0;
    end else if (clear) begin
      skid_v <= 1'b0;
    end else if (load) begin
      skid_v    <= 1'b1;
      skid_inst <= in_inst;
      skid_pc   <= in_pc;
    end else if (drain) begin
      skid_v <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// EV22 instruction fetch: owns the PC, drives the 1-cycle program ROM and
// registers instruction/PC/valid into the fetch/decode pipeline register.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter int unsigned    AW           = IFETCH_AW,
  parameter int unsigned    IW           = IFETCH_IW,
  parameter logic [AW-1:0]  RESET_VECTOR = '0,
  parameter logic [IW-1:0]  NOP_INST     = NOP_WORD
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          STALL,
  input  logic          REDIRECT,
  input  logic [AW-1:0] TARGET,
  output logic [AW-1:0] ROM_ADDR,
  input  logic [IW-1:0] ROM_DATA,
  output logic [IW-1:0] INST,
  output logic [AW-1:0] INST_PC,
  output logic          INST_VALID
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] issue_pc;
  logic          rom_v;

  logic [IW-1:0] skid_inst;
  logic [AW-1:0] skid_pc;
  logic          skid_v;
  logic          skid_load;
  logic          skid_drain;
  logic          advance;

  assign ROM_ADDR = pc_q;
  assign advance  = !REDIRECT && !STALL;

  // Only the first stalled cycle can see rom_v=1, so the skid never overflows.
  assign skid_load  = !REDIRECT && STALL && rom_v && !skid_v;
  assign skid_drain = advance && skid_v;

  fetch_skid #(
    .AW(AW),
    .IW(IW)
  ) u_skid (
    .clk       (CLK),
    .rst       (RESET),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (REDIRECT),
    .in_inst   (ROM_DATA),
    .in_pc     (issue_pc),
    .skid_inst (skid_inst),
    .skid_pc   (skid_pc),
    .skid_v    (skid_v)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q     <= RESET_VECTOR;
      issue_pc <= '0;
      rom_v    <= 1'b0;
    end else if (REDIRECT) begin
      pc_q  <= TARGET;
      rom_v <= 1'b0;
    end else if (STALL) begin
      rom_v <= 1'b0;
    end else begin
      pc_q     <= pc_q + AW'(1);
      issue_pc <= pc_q;
      rom_v    <= 1'b1;
    end
  end

  // Skid drains ahead of the ROM word; both cannot be valid together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      INST       <= NOP_INST;
      INST_PC    <= '0;
      INST_VALID <= 1'b0;
    end else if (REDIRECT) begin
      INST       <= NOP_INST;
      INST_VALID <= 1'b0;
    end else if (!STALL) begin
      if (skid_v) begin
        INST       <= skid_inst;
        INST_PC    <= skid_pc;
        INST_VALID <= 1'b1;
      end else if (rom_v) begin
        INST       <= ROM_DATA;
        INST_PC    <= issue_pc;
        INST_VALID <= 1'b1;
      end else begin
        INST       <= NOP_INST;
        INST_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: queue-based fetch model compared every
// cycle, plus literal checks for reset, latency, redirect, skid and PC wrap.
module tb_ifetch_stage;

  localparam int unsigned AW = 12;
  localparam int unsigned IW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] target;

  logic [AW-1:0] rom_addr, rom_addr_w;
  logic [IW-1:0] rom_data, rom_data_w;
  logic [IW-1:0] inst, inst_w;
  logic [AW-1:0] inst_pc, inst_pc_w;
  logic          inst_valid, inst_valid_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_stage #(
    .AW(AW), .IW(IW), .RESET_VECTOR(12'h000), .NOP_INST(20'h00000)
  ) dut (
    .CLK(clk), .RESET(rst), .STALL(stall), .REDIRECT(redirect), .TARGET(target),
    .ROM_ADDR(rom_addr), .ROM_DATA(rom_data),
    .INST(inst), .INST_PC(inst_pc), .INST_VALID(inst_valid)
  );

  ifetch_stage #(
    .AW(AW), .IW(IW), .RESET_VECTOR(12'hFFE), .NOP_INST(20'h00000)
  ) dut_w (
    .CLK(clk), .RESET(rst), .STALL(1'b0), .REDIRECT(1'b0), .TARGET(12'h000),
    .ROM_ADDR(rom_addr_w), .ROM_DATA(rom_data_w),
    .INST(inst_w), .INST_PC(inst_pc_w), .INST_VALID(inst_valid_w)
  );

  function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
    return 20'h10000 + {8'h00, a};
  endfunction

  always @(posedge clk) begin
    rom_data   <= rom_word(rom_addr);
    rom_data_w <= rom_word(rom_addr_w);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of addresses fetched but not yet handed to the decoder.
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_inst;
  logic [AW-1:0] m_ipc;
  logic          m_v;
  logic [AW-1:0] pending[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 12'h000;
      m_inst = 20'h00000;
      m_ipc = 12'h000;
      m_v = 1'b0;
      pending.delete();
    end else if (redirect) begin
      m_pc = target;
      m_inst = 20'h00000;
      m_v = 1'b0;
      pending.delete();
    end else if (!stall) begin
      if (pending.size() > 0) begin
        m_ipc = pending.pop_front();
        m_inst = rom_word(m_ipc);
        m_v = 1'b1;
      end else begin
        m_inst = 20'h00000;
        m_v = 1'b0;
      end
      pending.push_back(m_pc);
      m_pc = m_pc + 12'h001;
    end
  end

  logic [AW-1:0] last_pc;
  bit            have_last = 0;

  always @(posedge clk) begin
    #1;
    if (rst || redirect) begin
      have_last = 0;
    end
    if (!rst) begin
      chk("rom_addr", 32'(rom_addr), 32'(m_pc));
      chk("inst", 32'(inst), 32'(m_inst));
      chk("inst_pc", 32'(inst_pc), 32'(m_ipc));
      chk("inst_valid", 32'(inst_valid), 32'(m_v));
      if (!redirect && !stall && inst_valid) begin
        if (have_last) chk("pc_step", 32'(inst_pc), 32'(last_pc + 12'h001));
        last_pc = inst_pc;
        have_last = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  logic [IW-1:0] held;

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = '0;
    step(); step();
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_pc", 32'(inst_pc), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h000);
    chk("rst_addr_w", 32'(rom_addr_w), 32'hFFE);

    rst = 1'b0;
    step();
    chk("lat_c1_valid", 32'(inst_valid), 32'h0);
    chk("wrap_c1_valid", 32'(inst_valid_w), 32'h0);
    step();
    chk("lat_c2_valid", 32'(inst_valid), 32'h1);
    chk("lat_c2_inst", 32'(inst), 32'h10000);
    chk("lat_c2_pc", 32'(inst_pc), 32'h000);
    chk("wrap_pc0", 32'(inst_pc_w), 32'hFFE);
    step();
    chk("stream_inst1", 32'(inst), 32'h10001);
    chk("wrap_pc1", 32'(inst_pc_w), 32'hFFF);
    step();
    chk("stream_inst2", 32'(inst), 32'h10002);
    chk("wrap_pc2", 32'(inst_pc_w), 32'h000);
    chk("wrap_inst2", 32'(inst_w), 32'h10000);
    step();
    chk("wrap_pc3", 32'(inst_pc_w), 32'h001);
    chk("wrap_valid3", 32'(inst_valid_w), 32'h1);
    step();

    // single-cycle stall
    held = inst;
    stall = 1'b1;
    step();
    chk("stall1_hold", 32'(inst), 32'(held));
    stall = 1'b0;
    step();
    chk("stall1_next", 32'(inst), 32'(held + 20'h1));
    step(); step();

    // three-cycle stall
    held = inst;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall3_hold", 32'(inst), 32'(held));
    end
    stall = 1'b0;
    step();
    chk("stall3_next", 32'(inst), 32'(held + 20'h1));
    step(); step(); step();

    // redirect while streaming
    redirect = 1'b1; target = 12'h0A0;
    step();
    redirect = 1'b0;
    chk("redir_r1_inst", 32'(inst), 32'h0);
    chk("redir_r1_valid", 32'(inst_valid), 32'h0);
    chk("redir_r1_addr", 32'(rom_addr), 32'h0A0);
    step();
    chk("redir_r2_valid", 32'(inst_valid), 32'h0);
    step();
    chk("redir_r3_valid", 32'(inst_valid), 32'h1);
    chk("redir_r3_pc", 32'(inst_pc), 32'h0A0);
    chk("redir_r3_inst", 32'(inst), 32'h100A0);
    step(); step(); step();

    // redirect + stall with the skid loaded
    stall = 1'b1;
    step(); step();
    redirect = 1'b1; target = 12'h200;
    step();
    redirect = 1'b0;
    chk("rs_valid", 32'(inst_valid), 32'h0);
    chk("rs_addr", 32'(rom_addr), 32'h200);
    step();
    stall = 1'b0;
    step();
    chk("rs_noskid", 32'(inst_valid), 32'h0);
    step();
    chk("rs_first_valid", 32'(inst_valid), 32'h1);
    chk("rs_first_pc", 32'(inst_pc), 32'h200);
    step(); step();

    // async reset mid-stall with the skid loaded
    stall = 1'b1;
    step(); step();
    #1 rst = 1'b1;
    #1;
    chk("arst_inst", 32'(inst), 32'h0);
    chk("arst_valid", 32'(inst_valid), 32'h0);
    chk("arst_addr", 32'(rom_addr), 32'h000);
    stall = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("arst_c1_valid", 32'(inst_valid), 32'h0);
    step();
    chk("arst_c2_inst", 32'(inst), 32'h10000);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
